// File: rtl/seq_subtractor_if.sv
// Handshake and result bus between the ULA and the sequential subtractor.
// The slave modport is the subtractor side; the master modport is the requester side.
interface seq_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             EN;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   s;

    modport master (
        output start, a, b, EN,
        input  busy, done, s
    );

    modport slave (
        input  start, a, b, EN,
        output busy, done, s
    );
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle unsigned subtractor s = {borrow, a - b}, DIGIT bits per clock, LSB first.
// Optional macro SEQ_SUB_TRISTATE_EN: EN=0 floats s instead of forcing it to zero.
module seq_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_subtractor_if.slave   bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   result_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT:0]   digit_d;
    logic [WIDTH-1:0] diff_d;
    logic             last_d;

    // Digit stage: one DIGIT-wide ripple-borrow step, written into its slot of the difference
    always_comb begin
        digit_d = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                  - {{DIGIT{1'b0}}, borrow_q};
        diff_d  = diff_q;
        diff_d[int'(cnt_q) * DIGIT +: DIGIT] = digit_d[DIGIT-1:0];
        last_d  = (cnt_q == CW'(N - 1));
    end

    // Control FSM with operand shift registers, digit counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            result_q <= {(WIDTH+1){1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= 1'b0;
                        cnt_q    <= {CW{1'b0}};
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    diff_q   <= diff_d;
                    borrow_q <= digit_d[DIGIT];
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= {digit_d[DIGIT], diff_d};
                    end else begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Result bus gate: status flags stay visible regardless of EN
    always_comb begin
        if (bus.EN) begin
            bus.s = result_q;
        end else begin
`ifdef SEQ_SUB_TRISTATE_EN
            bus.s = {(WIDTH+1){1'bz}};
`else
            bus.s = {(WIDTH+1){1'b0}};
`endif
        end
    end
endmodule
